seg_scan_ctrl: RTL and testbench
================================

# seg_scan_ctrl

Time-multiplexed scan controller for a common-anode multi-digit seven-segment display. It holds a hex value of NUM_DIGITS nibbles in a shadow register and rotates through the digit positions at a programmable refresh rate. For each position it drives one nibble to the downstream hex-to-segment decoder and the matching active-low anode enable. New values are accepted through a valid/ack handshake only at frame boundaries, so a frame never shows a mix of old and new digits.

## Interface
- NUM_DIGITS, 4, number of display digits (>= 2)
- REFRESH_DIV, 50000, clock cycles per digit slot (>= 1)
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- value  input  4*NUM_DIGITS  hex value to display; nibble i drives digit position i; position 0 is the rightmost digit (LSB)
- value_valid  input  1  update request; held high until value_ack
- value_ack  output  1  one-cycle pulse; value is captured into shadow on this cycle's edge
- digit  output  4  nibble for the current slot; feeds the decoder's num input (zero-extended there)
- an  output  NUM_DIGITS  active-low anode enables; at most one bit low
- frame_done  output  1  one-cycle pulse on the last cycle of each full frame

## Operation
- Prescaler cnt counts 0..REFRESH_DIV-1, then wraps. tick = (cnt == REFRESH_DIV-1). With REFRESH_DIV=1, tick is high every cycle.
- Slot index idx (width clog2(NUM_DIGITS), min 1) increments on tick and wraps NUM_DIGITS-1 -> 0.
- Frame boundary = tick && idx == NUM_DIGITS-1. frame_done = frame boundary (combinational from registers).
- Handshake:
  - At a frame boundary with value_valid=1: value_ack=1 and shadow <= value on that edge.
  - value_valid=0 at the boundary: no ack, shadow unchanged.
  - Changes to value before the ack cycle are ignored; only the value present in the ack cycle is captured.
  - value_ack is never high outside a frame boundary.
  - Dropping value_valid before ack cancels the request.
- Outputs are decoded from registers, with no combinational path from inputs:
  - digit = shadow[4*idx +: 4]
  - an = ~(1 << idx), subject to blanking (see Configuration)
- The newly captured shadow takes effect in slot 0 of the next frame, i.e. the cycle after the ack edge.
- Reset values: cnt=0, idx=0, shadow=0, so an = all ones except bit0 low, digit=0, value_ack=0, frame_done=0. This holds for REFRESH_DIV>1; with REFRESH_DIV=1 the combinational frame_done/value_ack rules apply.
- Reset mid-frame: all state returns to reset values on the next edge. Any pending value_valid is not acknowledged in that cycle.

## Timing
- Each slot lasts exactly REFRESH_DIV cycles. A frame lasts NUM_DIGITS*REFRESH_DIV cycles.
- an and digit change only on the edge where tick=1 (or on reset). Both change on the same edge, so there is no inter-digit skew.
- value_valid-to-ack latency: 0 to NUM_DIGITS*REFRESH_DIV-1 cycles, depending on frame phase.
- frame_done and value_ack coincide when an update is taken.

## Configuration
- SEG_LZ_BLANK_EN:
  - Defined: leading-zero blanking. In slot i (i>0), an is driven all ones when shadow nibbles i..NUM_DIGITS-1 are all zero. Slot 0 is never blanked, so value 0 shows a single "0". digit is still driven normally; only an is suppressed.
  - Undefined: every slot is lit unconditionally, and the blanking logic is not present.

## Test plan
Bench uses NUM_DIGITS=4, REFRESH_DIV=4.
- Reset: rst high for 2 cycles -> an=1110, digit=0, value_ack=0, frame_done=0 for REFRESH_DIV cycles after release.
- Scan order: load 0x1234 -> slots show an/digit 1110/4, 1101/3, 1011/2, 0111/1, each for 4 cycles. frame_done pulses every 16 cycles, in the last cycle of the 0111 slot.
- Handshake: shadow=0x1234; raise value_valid with 0xABCD at frame cycle 5, then change value to 0xABCE at cycle 10 -> no ack until cycle 15. Ack pulses once and captures 0xABCE. The next frame shows E, C, B, A. value_ack stays low when value_valid=0.
- Reset mid-frame: shadow=0x1234, assert rst while idx=2 with value_valid=1 -> next edge gives an=1110, digit=0, shadow=0, and no value_ack in that cycle.
- Blanking with SEG_LZ_BLANK_EN defined, value 0x0050 -> slots 3 and 2 give an=1111; slot 1 gives an=1101, digit=5; slot 0 gives an=1110, digit=0. Value 0x0000 -> only slot 0 lit.
- Same stimulus without SEG_LZ_BLANK_EN -> all four slots lit with digits 0, 5, 0, 0 (positions 0..3).

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed scan controller for a common-anode seven-segment display
//
// Rotates through NUM_DIGITS positions, REFRESH_DIV clocks per position, and
// presents one nibble plus its active-low anode enable. A new value is taken
// only at the frame boundary, so a frame never mixes old and new digits.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   value        NUM_DIGITS nibbles to display, nibble 0 = rightmost digit
//   value_valid  update request, held until value_ack
//   value_ack    one-cycle pulse; value captured on this cycle's edge
//   digit        nibble of the current slot
//   an           active-low anode enables, at most one low
//   frame_done   one-cycle pulse on the last cycle of each frame
//
// Optional feature: define SEG_LZ_BLANK_EN for leading-zero blanking.
module seg_scan_ctrl #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic                    value_valid,
    output logic                    value_ack,
    output logic [3:0]              digit,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);
    localparam int CW = REFRESH_DIV > 1 ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;

    logic [CW-1:0]           cnt_q, cnt_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
    logic                    tick, last;
    logic [NUM_DIGITS-1:0]   an_base;

    assign tick       = cnt_q == CW'(REFRESH_DIV - 1);
    assign last       = idx_q == IW'(NUM_DIGITS - 1);
    assign frame_done = tick && last;
    // A reset in the same cycle wins over a pending request.
    assign value_ack  = frame_done && value_valid && !rst;

    always_comb begin
        cnt_d    = tick ? '0 : cnt_q + 1'b1;
        idx_d    = tick ? (last ? '0 : idx_q + 1'b1) : idx_q;
        shadow_d = value_ack ? value : shadow_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            idx_q    <= '0;
            shadow_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
        end
    end

    assign digit   = shadow_q[4*idx_q +: 4];
    assign an_base = ~(NUM_DIGITS'(1) << idx_q);

`ifdef SEG_LZ_BLANK_EN
    // upper_zero[g]: nibbles g..NUM_DIGITS-1 are all zero.
    logic [NUM_DIGITS-1:0] upper_zero;
    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_uz
        assign upper_zero[g] = shadow_q[4*NUM_DIGITS-1:4*g] == '0;
    end
    assign an = (idx_q != '0 && upper_zero[idx_q]) ? '1 : an_base;
`else
    assign an = an_base;
`endif
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: directed self-checking bench for seg_scan_ctrl (4 digits, 4 clocks per slot)
module tb_seg_scan_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] value = '0;
    logic        value_valid = 1'b0;
    logic        value_ack;
    logic [3:0]  digit;
    logic [3:0]  an;
    logic        frame_done;
    int          tests = 0;
    int          fails = 0;
    int          lat;

    seg_scan_ctrl #(.NUM_DIGITS(4), .REFRESH_DIV(4)) dut (
        .clk(clk),
        .rst(rst),
        .value(value),
        .value_valid(value_valid),
        .value_ack(value_ack),
        .digit(digit),
        .an(an),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Waits for value_ack within a bound, checks it arrived with the expected latency.
    task automatic wait_ack(input string tag, input int exp_lat);
        int n = 0;
        while (!value_ack && n < 40) begin
            step(1);
            n++;
        end
        chk({tag, "_ack_seen"}, 16'(value_ack), 16'd1);
        chk({tag, "_ack_lat"}, 16'(n), 16'(exp_lat));
        chk({tag, "_ack_fd"}, 16'(frame_done), 16'd1);
        lat = n;
    endtask

    // Walks one full frame from slot 0, cycle 0; packed nibble s = slot s expectation.
    task automatic chk_frame(input string tag, input logic [15:0] an_e, input logic [15:0] dig_e);
        for (int s = 0; s < 4; s++) begin
            for (int c = 0; c < 4; c++) begin
                chk({tag, "_an"}, 16'(an), 16'(an_e[4*s +: 4]));
                chk({tag, "_digit"}, 16'(digit), 16'(dig_e[4*s +: 4]));
                chk({tag, "_fd"}, 16'(frame_done), 16'(s == 3 && c == 3));
                chk({tag, "_ack"}, 16'(value_ack), 16'd0);
                step(1);
            end
        end
    endtask

    initial begin
        // Reset for two cycles, then hold reset outputs for a full slot.
        step(2);
        chk("rst_an", 16'(an), 16'hE);
        chk("rst_digit", 16'(digit), 16'h0);
        chk("rst_ack", 16'(value_ack), 16'h0);
        chk("rst_fd", 16'(frame_done), 16'h0);
        rst = 1'b0;
        #1;
        for (int c = 0; c < 4; c++) begin
            chk("rel_an", 16'(an), 16'hE);
            chk("rel_digit", 16'(digit), 16'h0);
            chk("rel_ack", 16'(value_ack), 16'h0);
            chk("rel_fd", 16'(frame_done), 16'h0);
            step(1);
        end
        // Now slot 1, cycle 0: boundary is 11 cycles away.
        value = 16'h1234;
        value_valid = 1'b1;
        #1;
        wait_ack("load1234", 11);
        step(1);
        value_valid = 1'b0;
        #1;
        chk_frame("scan1234", 16'h7BDE, 16'h1234);
        chk_frame("scan1234b", 16'h7BDE, 16'h1234);

        // Request at frame cycle 5, value changed at cycle 10, ack only at 15.
        step(5);
        value = 16'hABCD;
        value_valid = 1'b1;
        #1;
        chk("hs_c5_ack", 16'(value_ack), 16'h0);
        step(5);
        value = 16'hABCE;
        #1;
        chk("hs_c10_ack", 16'(value_ack), 16'h0);
        step(4);
        chk("hs_c14_ack", 16'(value_ack), 16'h0);
        chk("hs_c14_digit", 16'(digit), 16'h1);
        step(1);
        chk("hs_c15_ack", 16'(value_ack), 16'h1);
        chk("hs_c15_fd", 16'(frame_done), 16'h1);
        step(1);
        chk("hs_after_ack", 16'(value_ack), 16'h0);
        value_valid = 1'b0;
        #1;
        chk_frame("scanABCE", 16'h7BDE, 16'hABCE);

        // Mid-frame reset with a pending request.
        value = 16'h1234;
        value_valid = 1'b1;
        #1;
        wait_ack("reload", 15);
        step(1);
        value_valid = 1'b0;
        step(8);
        chk("mid_an_pre", 16'(an), 16'hB);
        chk("mid_digit_pre", 16'(digit), 16'h2);
        value_valid = 1'b1;
        rst = 1'b1;
        #1;
        chk("mid_ack_rst", 16'(value_ack), 16'h0);
        step(1);
        chk("mid_an", 16'(an), 16'hE);
        chk("mid_digit", 16'(digit), 16'h0);
        chk("mid_ack", 16'(value_ack), 16'h0);
        chk("mid_fd", 16'(frame_done), 16'h0);
        rst = 1'b0;
        value_valid = 1'b0;
        step(4);
        chk("mid_shadow_digit", 16'(digit), 16'h0);
`ifdef SEG_LZ_BLANK_EN
        chk("mid_slot1_an", 16'(an), 16'hF);
`else
        chk("mid_slot1_an", 16'(an), 16'hD);
`endif

        // Blanking stimulus: 0x0050 then 0x0000.
        value = 16'h0050;
        value_valid = 1'b1;
        #1;
        wait_ack("load0050", 11);
        step(1);
        value_valid = 1'b0;
        #1;
`ifdef SEG_LZ_BLANK_EN
        chk_frame("scan0050", 16'hFFDE, 16'h0050);
`else
        chk_frame("scan0050", 16'h7BDE, 16'h0050);
`endif
        value = 16'h0000;
        value_valid = 1'b1;
        #1;
        wait_ack("load0000", 15);
        step(1);
        value_valid = 1'b0;
        #1;
`ifdef SEG_LZ_BLANK_EN
        chk_frame("scan0000", 16'hFFFE, 16'h0000);
`else
        chk_frame("scan0000", 16'h7BDE, 16'h0000);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
